// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and widths for the instruction-fetch stage
package fetch_unit_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [PC_W-1:0]    PC_count;
        logic [INSTR_W-1:0] instr_code;
    } IF_ID;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - single-entry IF_ID buffer that parks an instruction during stalls
module fetch_hold_buf
    import fetch_unit_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  IF_ID d,
    output IF_ID q,
    output logic valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner issuing one imem request at a time and feeding the IF/ID register
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'h00,
    parameter int              PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output IF_ID               ifid_o
);

    fetch_state_e    state, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] inflight_pc, inflight_d;
    logic            discard, discard_d;
    logic            hold_load, hold_clear, hold_valid;
    IF_ID            hold_q, resp_word;

    assign resp_word.PC_count   = inflight_pc;
    assign resp_word.instr_code = imem_resp_data;
    assign imem_req_addr        = pc_q;

    fetch_hold_buf u_hold (
        .clk   (clk),
        .reset (reset),
        .load  (hold_load),
        .clear (hold_clear),
        .d     (resp_word),
        .q     (hold_q),
        .valid (hold_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= REQ;
            pc_q        <= RESET_PC;
            inflight_pc <= '0;
            discard     <= 1'b0;
        end else begin
            state       <= state_d;
            pc_q        <= pc_d;
            inflight_pc <= inflight_d;
            discard     <= discard_d;
        end
    end

    always_comb begin
        state_d        = state;
        pc_d           = pc_q;
        inflight_d     = inflight_pc;
        discard_d      = discard;
        imem_req_valid = 1'b0;
        ifid_o         = '0;
        hold_load      = 1'b0;
        hold_clear     = 1'b0;

        if (reset) begin
            // outputs stay quiet; registers reload on the edge
        end else if (redirect_valid) begin
            pc_d = redirect_pc & 8'hFC;
            unique case (state)
                WAIT: begin
                    if (imem_resp_valid) begin
                        discard_d = 1'b0;
                        state_d   = REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: begin
                    hold_clear = 1'b1;
                    state_d    = REQ;
                end
            endcase
        end else begin
            unique case (state)
                REQ: begin
                    imem_req_valid = 1'b1;
                    if (imem_req_ready) begin
                        inflight_d = pc_q;
                        pc_d       = pc_q + PC_W'(PC_STEP);
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (discard) begin
                            discard_d = 1'b0;
                            state_d   = REQ;
                        end else begin
                            ifid_o = resp_word;
                            if (stall) begin
                                hold_load = 1'b1;
                                state_d   = HOLD;
                            end else begin
                                // back-to-back: the next fetch issues while this word is consumed
                                imem_req_valid = 1'b1;
                                if (imem_req_ready) begin
                                    inflight_d = pc_q;
                                    pc_d       = pc_q + PC_W'(PC_STEP);
                                    state_d    = WAIT;
                                end else begin
                                    state_d = REQ;
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    if (hold_valid) begin
                        ifid_o = hold_q;
                    end
                    if (!stall) begin
                        hold_clear = 1'b1;
                        state_d    = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a stream-level model
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [7:0] RPC = 8'hF8;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [7:0]  imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    IF_ID        ifid_o;

    fetch_unit #(.RESET_PC(RPC), .PC_STEP(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .ifid_o          (ifid_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // memory image: nonzero words so a real instruction never looks like a bubble
    logic [31:0] mem [64];

    // architectural model: next PC to be delivered, next PC to be requested
    logic [7:0]  exp_pc, req_exp;
    bit          outstanding, out_stale;
    logic [7:0]  out_addr;
    int          out_delay;
    bit          held;
    logic [39:0] held_val;
    int          consumed;

    int p_stall, p_redir, p_ready, lat_max;
    bit recording;
    logic [7:0] acc_q [$];

    task automatic do_cycle(input bit rst);
        bit         req_needed, resp_now;
        logic [39:0] exp_ifid;
        logic [7:0]  tgt;
        @(negedge clk);
        reset           = rst;
        stall           = ($urandom_range(0, 99) < p_stall);
        redirect_valid  = ($urandom_range(0, 99) < p_redir);
        redirect_pc     = 8'($urandom);
        imem_req_ready  = ($urandom_range(0, 99) < p_ready);
        resp_now        = !rst && outstanding && (out_delay == 0);
        imem_resp_valid = resp_now;
        imem_resp_data  = resp_now ? mem[out_addr[7:2]] : 32'($urandom);
        #1;
        if (rst) begin
            check_eq("rst_req_valid", 40'(imem_req_valid), 40'd0);
            check_eq("rst_ifid", ifid_o, 40'd0);
            outstanding = 0;
            held        = 0;
            exp_pc      = RPC;
            req_exp     = RPC;
            return;
        end

        req_needed = !redirect_valid && !held &&
                     (!outstanding || (resp_now && !out_stale && !stall));
        check_eq("req_valid", 40'(imem_req_valid), 40'(req_needed));
        if (imem_req_valid)
            check_eq("req_addr", 40'(imem_req_addr), 40'(req_exp));

        if (redirect_valid) begin
            check_eq("redir_bubble", ifid_o, 40'd0);
            tgt     = redirect_pc & 8'hFC;
            exp_pc  = tgt;
            req_exp = tgt;
            held    = 0;
            if (outstanding) out_stale = 1;
        end else if (held) begin
            check_eq("hold_ifid", ifid_o, held_val);
            if (!stall) begin
                held = 0;
                exp_pc += 8'd4;
                consumed++;
            end
        end else if (resp_now && !out_stale) begin
            exp_ifid = {exp_pc, mem[exp_pc[7:2]]};
            check_eq("resp_ifid", ifid_o, exp_ifid);
            if (stall) begin
                held     = 1;
                held_val = exp_ifid;
            end else begin
                exp_pc += 8'd4;
                consumed++;
            end
        end else begin
            check_eq("bubble", ifid_o, 40'd0);
        end

        if (outstanding) begin
            if (resp_now) outstanding = 0;
            else out_delay--;
        end
        if (imem_req_valid && imem_req_ready) begin
            if (recording) acc_q.push_back(imem_req_addr);
            outstanding = 1;
            out_stale   = 0;
            out_addr    = imem_req_addr;
            out_delay   = $urandom_range(0, lat_max);
            req_exp    += 8'd4;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h3;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        outstanding = 0; out_stale = 0; out_delay = 0; held = 0; consumed = 0;
        exp_pc = RPC; req_exp = RPC; out_addr = '0; held_val = '0;

        // straight-line fetch from RESET_PC, crossing the FC->00 wrap
        p_stall = 0; p_redir = 0; p_ready = 100; lat_max = 0; recording = 0;
        do_cycle(1);
        do_cycle(1);
        recording = 1;
        for (int i = 0; i < 8; i++) do_cycle(0);
        recording = 0;
        check_eq("wrap_cnt", 40'(acc_q.size() >= 3), 40'd1);
        if (acc_q.size() >= 3) begin
            check_eq("wrap_a0", 40'(acc_q[0]), 40'hF8);
            check_eq("wrap_a1", 40'(acc_q[1]), 40'hFC);
            check_eq("wrap_a2", 40'(acc_q[2]), 40'h00);
        end

        // long stalls with the memory stuck not-ready
        p_stall = 80; p_redir = 0; p_ready = 20; lat_max = 2;
        for (int i = 0; i < 300; i++) do_cycle(0);

        // mixed random traffic, redirects and occasional mid-flight reset
        p_stall = 30; p_redir = 6; p_ready = 70; lat_max = 3;
        for (int i = 0; i < 4000; i++) do_cycle($urandom_range(0, 199) == 0);

        check_eq("progress", 40'(consumed >= 200), 40'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
